// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller. Sits behind the flag checker, tracks
// hunt/flag/data state, removes stuffed zeros, assembles LSB-first octets
// and reports per-frame status and length.
module hdlc_rx_frame_ctrl #(
  parameter int MIN_BYTES = 4,
  parameter int MAX_BYTES = 2048,
  parameter int LEN_W     = 12
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             BitVld,
  input  logic             SRXD,
  input  logic             FFlag,
  input  logic             EFlag,
  output logic [7:0]       RxData,
  output logic             RxVld,
  output logic             RxSof,
  output logic             RxEof,
  output logic [2:0]       RxStat,
  output logic [LEN_W-1:0] RxLen,
  output logic             Sync
);

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_ABORT = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_SHORT = 3'd3;
  localparam logic [2:0] ST_LONG  = 3'd4;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {HUNT, FLAG, DATA} state_t;

  state_t           state, state_nxt;
  logic [2:0]       skip, skip_nxt;
  logic [2:0]       ones, ones_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [LEN_W-1:0] bytecnt, bytecnt_nxt;
  logic [6:0]       shreg, shreg_nxt;
  logic             sof_sent, sof_sent_nxt;
  logic [7:0]       data_nxt;
  logic             vld_nxt, sof_nxt, eof_nxt;
  logic [2:0]       stat_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic [7:0]       octet;
  logic             abort_ev;

  // The shifter only keeps the previous seven bits; the current sample
  // completes the octet (first received bit ends up in bit 0).
  assign octet    = {SRXD, shreg};
  // Disabling the block mid-frame behaves exactly like a received abort.
  assign abort_ev = !En || (BitVld && EFlag);
  assign Sync     = (state != HUNT);

  // Next-state, counter and output decisions for the current sample
  always_comb begin
    state_nxt    = state;
    skip_nxt     = skip;
    ones_nxt     = ones;
    bitcnt_nxt   = bitcnt;
    bytecnt_nxt  = bytecnt;
    shreg_nxt    = shreg;
    sof_sent_nxt = sof_sent;
    data_nxt     = RxData;
    vld_nxt      = 1'b0;
    sof_nxt      = 1'b0;
    eof_nxt      = 1'b0;
    stat_nxt     = RxStat;
    len_nxt      = RxLen;

    if (abort_ev) begin
      if (sof_sent) begin
        eof_nxt  = 1'b1;
        stat_nxt = ST_ABORT;
        len_nxt  = bytecnt;
      end
      state_nxt    = HUNT;
      skip_nxt     = 3'd0;
      ones_nxt     = 3'd0;
      bitcnt_nxt   = 3'd0;
      bytecnt_nxt  = '0;
      sof_sent_nxt = 1'b0;
    end else if (BitVld) begin
      if (FFlag) begin
        // A frame that never produced an octet is dropped without an EOF.
        if (state == DATA && sof_sent) begin
          eof_nxt = 1'b1;
          len_nxt = bytecnt;
          if (bitcnt != 3'd0)      stat_nxt = ST_ALIGN;
          else if (bytecnt < MIN_LEN) stat_nxt = ST_SHORT;
          else                     stat_nxt = ST_OK;
        end
        // Skip the remaining seven flag bits; a flag seen while skipping
        // restarts the skip so shared-zero flags are handled.
        state_nxt    = FLAG;
        skip_nxt     = 3'd7;
        ones_nxt     = 3'd0;
        bitcnt_nxt   = 3'd0;
        bytecnt_nxt  = '0;
        sof_sent_nxt = 1'b0;
      end else if (state == HUNT) begin
        state_nxt = HUNT;
      end else if (state == FLAG && skip != 3'd0) begin
        skip_nxt = skip - 3'd1;
      end else begin
        state_nxt = DATA;
        if (ones == 3'd5 && !SRXD) begin
          ones_nxt = 3'd0;
        end else begin
          shreg_nxt  = octet[7:1];
          ones_nxt   = SRXD ? ((ones == 3'd7) ? 3'd7 : ones + 3'd1) : 3'd0;
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (bytecnt == MAX_LEN) begin
              // Over-length: the octet is not delivered and the frame closes.
              eof_nxt      = 1'b1;
              stat_nxt     = ST_LONG;
              len_nxt      = MAX_LEN;
              state_nxt    = HUNT;
              ones_nxt     = 3'd0;
              bitcnt_nxt   = 3'd0;
              bytecnt_nxt  = '0;
              sof_sent_nxt = 1'b0;
            end else begin
              vld_nxt      = 1'b1;
              data_nxt     = octet;
              sof_nxt      = !sof_sent;
              sof_sent_nxt = 1'b1;
              bytecnt_nxt  = bytecnt + 1'b1;
            end
          end
        end
      end
    end
  end

  // Frame state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Counters, octet shifter and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      skip     <= 3'd0;
      ones     <= 3'd0;
      bitcnt   <= 3'd0;
      bytecnt  <= '0;
      shreg    <= 7'd0;
      sof_sent <= 1'b0;
      RxData   <= 8'd0;
      RxVld    <= 1'b0;
      RxSof    <= 1'b0;
      RxEof    <= 1'b0;
      RxStat   <= ST_OK;
      RxLen    <= '0;
    end else begin
      skip     <= skip_nxt;
      ones     <= ones_nxt;
      bitcnt   <= bitcnt_nxt;
      bytecnt  <= bytecnt_nxt;
      shreg    <= shreg_nxt;
      sof_sent <= sof_sent_nxt;
      RxData   <= data_nxt;
      RxVld    <= vld_nxt;
      RxSof    <= sof_nxt;
      RxEof    <= eof_nxt;
      RxStat   <= stat_nxt;
      RxLen    <= len_nxt;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Bench for hdlc_rx_frame_ctrl: builds serial line streams, derives the
// flag checker's window indications, and scoreboards octets and EOFs.
module tb_hdlc_rx_frame_ctrl;
  localparam int MIN_B = 4;
  localparam int MAX_B = 8;
  localparam int LW    = 12;

  logic          Clk = 1'b0;
  logic          Rst, En, BitVld, SRXD, FFlag, EFlag;
  logic [7:0]    RxData;
  logic          RxVld, RxSof, RxEof;
  logic [2:0]    RxStat;
  logic [LW-1:0] RxLen;
  logic          Sync;

  hdlc_rx_frame_ctrl #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B), .LEN_W(LW)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .BitVld(BitVld), .SRXD(SRXD),
    .FFlag(FFlag), .EFlag(EFlag), .RxData(RxData), .RxVld(RxVld),
    .RxSof(RxSof), .RxEof(RxEof), .RxStat(RxStat), .RxLen(RxLen), .Sync(Sync)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         eof;
    logic [7:0] data;
    bit         sof;
    int         stat;
    int         len;
  } ev_t;

  ev_t exp_q[$];
  bit  line[$];
  bit  raw[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void exp_byte(input logic [7:0] d, input bit s);
    ev_t e;
    e.eof = 1'b0; e.data = d; e.sof = s; e.stat = 0; e.len = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_eof(input int st, input int ln);
    ev_t e;
    e.eof = 1'b1; e.data = 8'd0; e.sof = 1'b0; e.stat = st; e.len = ln;
    exp_q.push_back(e);
  endfunction

  // Frame-level reference: what a receiver must report for a frame of n
  // payload octets followed by nx residual bits and a flag or an abort.
  function automatic void expect_frame(input logic [79:0] pl, input int n,
                                       input int nx, input bit abort);
    int m;
    m = (n > MAX_B) ? MAX_B : n;
    for (int b = 0; b < m; b++) exp_byte(pl[8*b +: 8], b == 0);
    if (n > MAX_B)      exp_eof(4, MAX_B);
    else if (n > 0) begin
      if (abort)        exp_eof(1, n);
      else if (nx > 0)  exp_eof(2, n);
      else if (n < MIN_B) exp_eof(3, n);
      else              exp_eof(0, n);
    end
  endfunction

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge Clk) begin
    ev_t e;
    if (RxVld || RxEof) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'(RxData), -1);
      end else begin
        e = exp_q.pop_front();
        check("rx_event_kind", int'(RxEof), int'(e.eof));
        if (RxVld) begin
          check("rxdata", int'(RxData), int'(e.data));
          check("rxsof", int'(RxSof), int'(e.sof));
        end
        if (RxEof) begin
          check("rxstat", int'(RxStat), e.stat);
          check("rxlen", int'(RxLen), e.len);
        end
      end
    end
  end

  function automatic void add_ones(input int n);
    for (int i = 0; i < n; i++) line.push_back(1'b1);
  endfunction

  function automatic void add_flag();
    line.push_back(1'b0);
    add_ones(6);
    line.push_back(1'b0);
  endfunction

  // Flag sharing its opening zero with the previous flag's closing zero
  function automatic void add_shared_flag();
    add_ones(6);
    line.push_back(1'b0);
  endfunction

  function automatic void add_raw_bytes(input logic [79:0] pl, input int n);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 8; k++) raw.push_back(pl[8*b+k]);
  endfunction

  function automatic void add_raw_bits(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) raw.push_back(v[k]);
  endfunction

  // Zero insertion after every five consecutive ones
  function automatic void stuff_raw();
    int n1;
    n1 = 0;
    foreach (raw[i]) begin
      line.push_back(raw[i]);
      if (raw[i]) begin
        n1++;
        if (n1 == 5) begin
          line.push_back(1'b0);
          n1 = 0;
        end
      end else begin
        n1 = 0;
      end
    end
    raw.delete();
  endfunction

  function automatic void add_frame(input logic [79:0] pl, input int n, input int nx,
                                    input logic [7:0] xb, input bit abort);
    add_raw_bytes(pl, n);
    add_raw_bits(xb, nx);
    stuff_raw();
    if (abort) begin
      line.push_back(1'b0);
      add_ones(7 + $urandom_range(0, 3));
    end
    add_flag();
  endfunction

  // Plays the line as checker samples; bits past the end read as idle ones.
  task automatic play(input bit gaps);
    logic [7:0] w;
    for (int i = 0; i < line.size(); i++) begin
      for (int k = 0; k < 8; k++) w[k] = (i + k < line.size()) ? line[i+k] : 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        BitVld = 1'b0;
        @(posedge Clk); #1;
      end
      BitVld = 1'b1;
      SRXD   = w[0];
      FFlag  = (w == 8'h7E);
      EFlag  = (w[6:0] == 7'h7F);
      @(posedge Clk); #1;
      BitVld = 1'b0;
    end
    line.delete();
  endtask

  task automatic drain(input string name);
    BitVld = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rxdata"}, int'(RxData), 0);
    check({tag, "_rxvld"},  int'(RxVld), 0);
    check({tag, "_rxsof"},  int'(RxSof), 0);
    check({tag, "_rxeof"},  int'(RxEof), 0);
    check({tag, "_rxstat"}, int'(RxStat), 0);
    check({tag, "_rxlen"},  int'(RxLen), 0);
    check({tag, "_sync"},   int'(Sync), 0);
  endtask

  typedef struct {
    int          n;
    logic [79:0] pl;
    int          nx;
    logic [7:0]  xb;
    bit          abort;
    int          nvld;
    bit          eof;
    int          stat;
    int          len;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [79:0] pl;
    int          n, nx, r;
    logic [7:0]  xb;
    bit          ab;

    tbl[0]  = '{4,  80'h55AA0301,           0, 8'h00, 1'b0, 4, 1'b1, 0, 4};
    tbl[1]  = '{2,  80'hFF3E,               0, 8'h00, 1'b0, 2, 1'b1, 3, 2};
    tbl[2]  = '{2,  80'h55AA,               0, 8'h00, 1'b1, 2, 1'b1, 1, 2};
    tbl[3]  = '{4,  80'h04030201,           3, 8'h05, 1'b0, 4, 1'b1, 2, 4};
    tbl[4]  = '{9,  80'h090807060504030201, 0, 8'h00, 1'b0, 8, 1'b1, 4, 8};
    tbl[5]  = '{0,  80'h0,                  0, 8'h00, 1'b0, 0, 1'b0, 0, 0};
    tbl[6]  = '{5,  80'hFFFFFFFFFF,         0, 8'h00, 1'b0, 5, 1'b1, 0, 5};
    tbl[7]  = '{8,  80'h7E7E7E7E7E7E7E7E,   0, 8'h00, 1'b0, 8, 1'b1, 0, 8};
    tbl[8]  = '{3,  80'h0000C0,             0, 8'h00, 1'b0, 3, 1'b1, 3, 3};
    tbl[9]  = '{1,  80'h81,                 5, 8'h1F, 1'b0, 1, 1'b1, 2, 1};
    tbl[10] = '{0,  80'h0,                  4, 8'h0F, 1'b0, 0, 1'b0, 0, 0};
    tbl[11] = '{1,  80'hFE,                 0, 8'h00, 1'b1, 1, 1'b1, 1, 1};

    Rst = 1'b1; En = 1'b1; BitVld = 1'b0; SRXD = 1'b0; FFlag = 1'b0; EFlag = 1'b0;
    @(posedge Clk); @(negedge Clk);
    check_idle("reset");
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Directed frame table
    for (int t = 0; t < 12; t++) begin
      for (int b = 0; b < tbl[t].nvld; b++) exp_byte(tbl[t].pl[8*b +: 8], b == 0);
      if (tbl[t].eof) exp_eof(tbl[t].stat, tbl[t].len);
      add_ones(8);
      add_flag();
      add_frame(tbl[t].pl, tbl[t].n, tbl[t].nx, tbl[t].xb, tbl[t].abort);
      add_ones(8);
      play(t[0]);
      drain($sformatf("table%0d_events", t));
    end

    // Shared-zero and consecutive flags produce nothing but keep sync
    add_ones(8);
    add_flag(); add_shared_flag(); add_shared_flag(); add_flag(); add_shared_flag();
    play(1'b1);
    check("shared_flag_sync", int'(Sync), 1);
    drain("shared_flag_events");

    // Abort drops sync; the next flag regains it
    exp_byte(8'h12, 1'b1); exp_byte(8'h34, 1'b0); exp_eof(1, 2);
    add_ones(8); add_flag();
    add_raw_bytes(80'h3412, 2); stuff_raw();
    line.push_back(1'b0); add_ones(8);
    play(1'b0);
    check("abort_sync_low", int'(Sync), 0);
    add_flag();
    play(1'b0);
    check("resync_after_flag", int'(Sync), 1);
    drain("abort_events");

    // Reset mid-frame: outputs clear, no EOF afterwards
    exp_byte(8'hA5, 1'b1); exp_byte(8'h5A, 1'b0);
    add_ones(8); add_flag();
    add_raw_bytes(80'h5AA5, 2); add_raw_bits(8'h00, 3); stuff_raw();
    play(1'b0);
    Rst = 1'b1;
    @(posedge Clk); @(negedge Clk);
    check_idle("midrst");
    #1 Rst = 1'b0;
    add_flag(); add_ones(8);
    play(1'b0);
    drain("midrst_events");

    // Enable drop mid-frame aborts; status holds afterwards
    exp_byte(8'h11, 1'b1); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b0); exp_eof(1, 3);
    add_ones(8); add_flag();
    add_raw_bytes(80'h332211, 3); add_raw_bits(8'h00, 3); stuff_raw();
    play(1'b0);
    En = 1'b0; BitVld = 1'b1; SRXD = 1'b1; FFlag = 1'b1;
    repeat (2) begin @(posedge Clk); #1; end
    check("en_low_sync", int'(Sync), 0);
    En = 1'b1; BitVld = 1'b0; FFlag = 1'b0; SRXD = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    check("rxstat_hold", int'(RxStat), 1);
    check("rxlen_hold", int'(RxLen), 3);
    drain("en_drop_events");

    // Randomized frame stream against the frame-level reference
    add_ones(8); add_flag();
    for (int f = 0; f < 40; f++) begin
      n  = $urandom_range(0, 10);
      pl = '0;
      for (int b = 0; b < 10; b++) pl[8*b +: 8] = 8'($urandom);
      r  = $urandom_range(0, 9);
      ab = (r < 2);
      nx = (r >= 2 && r < 4) ? $urandom_range(1, 7) : 0;
      xb = 8'($urandom);
      expect_frame(pl, n, nx, ab);
      add_frame(pl, n, nx, xb, ab);
      r = $urandom_range(0, 3);
      if (r == 0) add_shared_flag();
      else if (r == 1) begin add_ones(9); add_flag(); end
    end
    add_ones(8);
    play(1'b1);
    drain("random_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
